// File: rtl/striping_lanes.sv
// Tx byte-striping stage: gathers the serial symbol stream into LANES-wide rows,
// frames packets so END lands in the last lane. Optional macro: STRIPE_IDLE_FILL_EN.
module striping_lanes #(
  parameter int LANES = 4,
  parameter int W     = 8,
  parameter int CW    = $clog2(LANES)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [W-1:0]       fromMux,
  input  logic               fromMux_valid,
  output logic [LANES*W-1:0] TL,
  output logic               TL_valid,
  output logic               frame_err
);

  localparam logic [W-1:0] COM = W'(8'hBC);
  localparam logic [W-1:0] PAD = W'(8'hF7);
  localparam logic [W-1:0] SKP = W'(8'h1C);
  localparam logic [W-1:0] STP = W'(8'hFB);
  localparam logic [W-1:0] SDP = W'(8'h5C);
  localparam logic [W-1:0] ENDS = W'(8'hFD);
  localparam logic [W-1:0] EDB = W'(8'hFE);
  localparam logic [W-1:0] IDL = W'(8'h7C);
  localparam logic [CW-1:0] LAST = CW'(LANES - 1);

  typedef enum logic {IDLE, PKT} state_t;

  state_t         state, state_next;
  logic [CW-1:0]  cnt, cnt_next;
  logic [W-1:0]   row      [LANES];
  logic [W-1:0]   row_next [LANES];
  logic [LANES*W-1:0] row_flat;
  logic           emit, abort;
  logic           is_start, is_os, is_end;

  assign is_start = (fromMux == STP) || (fromMux == SDP);
  assign is_os    = (fromMux == COM) || (fromMux == SKP) || (fromMux == IDL);
  assign is_end   = (fromMux == ENDS);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (fromMux_valid) begin
      case (state)
        IDLE:    if (is_start) state_next = PKT;
        PKT:     if (is_end || is_os) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    row_next = row;
    cnt_next = cnt;
    emit     = 1'b0;
    abort    = 1'b0;
    if (fromMux_valid) begin
      case (state)
        IDLE: begin
          if (is_start) begin
            row_next[0] = fromMux;
            cnt_next    = CW'(1);
          end else if (is_os) begin
            for (int k = 0; k < LANES; k++) row_next[k] = fromMux;
            emit = 1'b1;
          end
        end
        PKT: begin
          if (is_end || is_os) begin
            // Close the row: pad from the current slot, terminator in the last lane.
            for (int k = 0; k < LANES; k++)
              if (CW'(k) >= cnt) row_next[k] = PAD;
            row_next[LANES-1] = is_end ? ENDS : EDB;
            emit     = 1'b1;
            abort    = is_os;
            cnt_next = '0;
          end else begin
            row_next[cnt] = fromMux;
            if (cnt == LAST) begin
              emit     = 1'b1;
              cnt_next = '0;
            end else begin
              cnt_next = cnt + CW'(1);
            end
          end
        end
        default: cnt_next = '0;
      endcase
    end
`ifdef STRIPE_IDLE_FILL_EN
    else if (state == IDLE) begin
      for (int k = 0; k < LANES; k++) row_next[k] = IDL;
      emit = 1'b1;
    end
`endif
  end

  always_comb begin
    row_flat = '0;
    for (int k = 0; k < LANES; k++) row_flat[k*W +: W] = row_next[k];
  end

  // NOTE: the row buffer is only LANES registers, so it is reset along with the rest.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt       <= '0;
      for (int k = 0; k < LANES; k++) row[k] <= '0;
      TL        <= '0;
      TL_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      cnt       <= cnt_next;
      row       <= row_next;
      TL_valid  <= emit;
      frame_err <= abort;
      if (emit) TL <= row_flat;
    end
  end

endmodule

// File: tb/tb_striping_lanes.sv
// Bench for striping_lanes: queue-based row model compared every cycle, plus
// literal row checks. Honours STRIPE_IDLE_FILL_EN like the design.
module tb_striping_lanes;
  localparam int LANES = 4;
  localparam int W     = 8;

  localparam logic [W-1:0] PAD = 8'hF7;
  localparam logic [W-1:0] EDB = 8'hFE;
  localparam logic [W-1:0] ENDS = 8'hFD;

  logic               clk = 1'b0;
  logic               reset;
  logic [W-1:0]       fromMux;
  logic               fromMux_valid;
  logic [LANES*W-1:0] TL;
  logic               TL_valid;
  logic               frame_err;

  int  n_checks = 0;
  int  n_fail   = 0;
  bit  run      = 1'b0;

  striping_lanes #(.LANES(LANES), .W(W)) dut (
    .clk           (clk),
    .reset         (reset),
    .fromMux       (fromMux),
    .fromMux_valid (fromMux_valid),
    .TL            (TL),
    .TL_valid      (TL_valid),
    .frame_err     (frame_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Model: the partial row is a queue of symbols; a row leaves when it holds LANES.
  logic [W-1:0]       cur[$];
  bit                 in_pkt;
  logic [LANES*W-1:0] exp_tl;
  bit                 exp_v, exp_e;

  task automatic emit_row();
    for (int k = 0; k < LANES; k++) exp_tl[k*W +: W] = cur[k];
    exp_v = 1'b1;
    cur.delete();
  endtask

  task automatic model_sym(input logic [W-1:0] s);
    bit os;
    os = (s == 8'hBC) || (s == 8'h1C) || (s == 8'h7C);
    if (!in_pkt) begin
      if (s == 8'hFB || s == 8'h5C) begin
        cur.delete();
        cur.push_back(s);
        in_pkt = 1'b1;
      end else if (os) begin
        cur.delete();
        repeat (LANES) cur.push_back(s);
        emit_row();
      end
    end else if (s == ENDS || os) begin
      while (cur.size() < LANES - 1) cur.push_back(PAD);
      cur.push_back(os ? EDB : ENDS);
      emit_row();
      exp_e  = os;
      in_pkt = 1'b0;
    end else begin
      cur.push_back(s);
      if (cur.size() == LANES) emit_row();
    end
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      cur.delete();
      in_pkt = 1'b0;
      exp_tl = '0;
      exp_v  = 1'b0;
      exp_e  = 1'b0;
    end else begin
      exp_v = 1'b0;
      exp_e = 1'b0;
      if (fromMux_valid) model_sym(fromMux);
`ifdef STRIPE_IDLE_FILL_EN
      else if (!in_pkt) begin
        cur.delete();
        repeat (LANES) cur.push_back(8'h7C);
        emit_row();
      end
`endif
    end
  end

  always @(negedge clk) begin
    if (run && !reset) begin
      check("tl_valid", TL_valid, exp_v);
      check("frame_err", frame_err, exp_e);
      check("tl", TL, exp_tl);
    end
  end

  task automatic send(input logic v, input logic [W-1:0] s);
    @(posedge clk);
    #1;
    fromMux_valid = v;
    fromMux       = s;
  endtask

  // Apply a symbol list, then one idle cycle, then sample the row it produced.
  task automatic burst(input logic [W-1:0] syms[$]);
    foreach (syms[i]) send(1'b1, syms[i]);
    send(1'b0, '0);
    @(negedge clk);
  endtask

  initial begin
    reset         = 1'b1;
    fromMux       = '0;
    fromMux_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_tl", TL, 32'h0);
    check("reset_valid", TL_valid, 1'b0);
    check("reset_err", frame_err, 1'b0);
    reset = 1'b0;
    run   = 1'b1;
    repeat (3) send(1'b0, '0);

    burst('{8'hBC});
    check("com_row", TL, 32'hBCBCBCBC);
    check("com_valid", TL_valid, 1'b1);

    burst('{8'hFB, 8'h11, 8'h22, 8'h33, 8'h44});
    check("pkt_row1", dut.TL, 32'h332211FB);
    burst('{8'h55, 8'hFD});
    check("pkt_row2", TL, 32'hFDF75544);

    burst('{8'h42, 8'hFD, 8'hF7});
    burst('{8'h5C, 8'hAA, 8'hBB, 8'hFD});
    check("sdp_row", TL, 32'hFDBBAA5C);

    burst('{8'hFB, 8'h01, 8'h1C});
    check("abort_row", TL, 32'hFEF701FB);
    check("abort_err", frame_err, 1'b1);
    burst('{8'h7C});
    check("idl_row", TL, 32'h7C7C7C7C);
    check("idl_no_err", frame_err, 1'b0);

    burst('{8'hFB, 8'h01, 8'h02, 8'h03, 8'hFD});
    check("end_cnt0", TL, 32'hFDF7F7F7);
    burst('{8'hFB, 8'h0A, 8'h0B, 8'h0C, 8'hBC});
    check("abort_cnt0", TL, 32'hFEF7F7F7);

    send(1'b1, 8'hFB);
    send(1'b0, '0);
    send(1'b1, 8'h11);
    send(1'b0, '0);
    burst('{8'h22, 8'h33});
    check("gap_row", TL, 32'h332211FB);
    burst('{8'hFD});
    check("gap_end", TL, 32'hFDF7F7F7);

    burst('{8'hFB, 8'hFB, 8'h5C, 8'h01, 8'hFD});
    check("restart_end", TL, 32'hFDF7F7F7);

    send(1'b1, 8'hFB);
    send(1'b1, 8'h11);
    @(posedge clk);
    #2;
    reset         = 1'b1;
    fromMux_valid = 1'b0;
    #1;
    check("midrst_tl", TL, 32'h0);
    check("midrst_valid", TL_valid, 1'b0);
    check("midrst_err", frame_err, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    burst('{8'hFB, 8'hAA, 8'hBB, 8'hCC});
    check("post_rst_row", TL, 32'hCCBBAAFB);
    check("post_rst_valid", TL_valid, 1'b1);

    repeat (3) send(1'b0, '0);
    @(negedge clk);
    run = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/striping_lanes.md
Name: striping_lanes

Overview:
- Parametrised Tx byte-striping stage. Sits between the Tx symbol mux and the per-lane encoders.
- Collects the serial byte stream from the mux into rows of LANES bytes. Each completed row is presented on all lanes at once.
- Handles packet framing (STP/SDP..END): pads so END always lands in the last lane. Broadcasts ordered-set symbols (COM/SKP/IDL) to all lanes. Aborts malformed packets with EDB.

Parameters:
- LANES, 4, number of output lanes; any integer >= 2.
- W, 8, symbol width in bits.
- CW, $clog2(LANES), width of the internal slot counter (derived; do not override).

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- fromMux  input  W  symbol from Tx mux.
- fromMux_valid  input  1  fromMux carries a symbol this cycle.
- TL  output  LANES*W  striped row; lane k occupies TL[k*W +: W].
- TL_valid  output  1  one-cycle pulse: new row on TL.
- frame_err  output  1  one-cycle pulse: packet aborted.

Behaviour:
- Symbol constants: COM=BC, PAD=F7, SKP=1C, STP=FB, SDP=5C, END=FD, EDB=FE, IDL=7C (hex; low 8 bits, zero-extended if W>8).
- Reset (async, active-high):
  - TL=0, TL_valid=0, frame_err=0.
  - state=IDLE, slot count cnt=0, row buffer cleared.
  - Reset mid-packet discards the partial row; no row is emitted.
- Registers and outputs:
  - All outputs are registered.
  - A row appears on TL with TL_valid=1 in the cycle after the symbol that completes it is accepted (latency 1).
  - TL holds its last value between rows. TL_valid and frame_err are single-cycle pulses.
- fromMux_valid=0: no state change; TL_valid=0 (unless the optional feature is enabled).
- State IDLE:
  - STP or SDP: row slot0 <= symbol, cnt <= 1, go to PKT.
  - COM, SKP or IDL: emit a row with all lanes = symbol; cnt stays 0.
  - Any other symbol: ignored; no output.
- State PKT:
  - Data symbol, or a repeated STP/SDP: slot[cnt] <= symbol.
    - If cnt==LANES-1: emit the row, cnt <= 0.
    - Otherwise: cnt <= cnt+1.
  - END:
    - Slots cnt..LANES-2 <= PAD; slot LANES-1 <= END.
    - Emit the row, cnt <= 0, go to IDLE.
    - END with cnt==0 gives the row PAD..PAD,END.
    - END with cnt==LANES-1 gives no padding.
  - COM, SKP or IDL (ordered set inside a packet):
    - Fill the remaining slots with PAD and place EDB in lane LANES-1. If cnt==0, the row is PAD..PAD,EDB.
    - Emit the row, pulse frame_err, cnt <= 0, go to IDLE.
    - The ordered set itself is dropped.
- Counter wraps only via an explicit reset to 0; cnt never exceeds LANES-1.
- The block has no backpressure: one symbol is accepted per valid cycle.

Optional Feature:
- Macro STRIPE_IDLE_FILL_EN.
- Defined: in IDLE, a cycle with fromMux_valid=0 emits an all-IDL row (TL_valid=1) on the next cycle, so the lanes never starve. Idle cycles in PKT still emit nothing.
- Undefined: idle cycles emit nothing; TL_valid stays 0.

Test Plan (LANES=4, W=8):
- Reset asserted mid-stream -> TL=0, TL_valid=0, frame_err=0 immediately. After release, the first STP starts a fresh row.
- IDLE, then COM accepted -> next cycle TL=BC_BC_BC_BC, TL_valid=1 for exactly one cycle.
- Packet STP,11,22,33,44,55,END:
  - Row 1: lane0..3 = FB,11,22,33.
  - Row 2: lane0..3 = 44,55,F7,FD.
  - Each row is valid one cycle after its last symbol.
- Packet SDP,AA,BB,END -> single row 5C,AA,BB,FD, no PAD; state returns to IDLE.
- Packet STP,01,SKP -> row FB,01,F7,FE and frame_err=1 on the same cycle. The following IDL is broadcast normally.
- With STRIPE_IDLE_FILL_EN: 3 idle cycles in IDLE -> 3 consecutive rows 7C_7C_7C_7C. Without the macro -> TL_valid stays 0.
- Valid gaps inside a packet (STP, gap, 11, gap, 22, 33) -> the row is unchanged and emitted only after 33.
